// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data memory: control encodings,
// fault causes, FSM states and the byte-lane store/load helpers.
package dmem_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b011,
    LD_LHU = 3'b100
  } load_ctrl_e;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } store_ctrl_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_RANGE    = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  function automatic logic [3:0] store_mask(store_ctrl_e ctrl, logic [1:0] offset);
    logic [3:0] base;
    case (ctrl)
      ST_SB:   base = 4'b0001;
      ST_SH:   base = 4'b0011;
      ST_SW:   base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return base << offset;
  endfunction

  // Replicating the datum across all lanes lets the byte mask alone pick the target bytes.
  function automatic logic [31:0] store_data(store_ctrl_e ctrl, logic [31:0] wdata);
    case (ctrl)
      ST_SB:   return {4{wdata[7:0]}};
      ST_SH:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(load_ctrl_e ctrl, logic [1:0] offset,
                                              logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (ctrl)
      LD_LB:   return {{24{b[7]}}, b};
      LD_LH:   return {{16{h[15]}}, h};
      LD_LW:   return word;
      LD_LBU:  return {24'h0, b};
      LD_LHU:  return {16'h0, h};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port,
// written in the shape synthesis maps onto block RAM.
module dmem_ram #(
  parameter int DEPTH_WORDS = 32,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: the array and read register carry no reset; a reset would block RAM inference.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_hs.sv
// Data memory behind valid/ready request and response channels: one transaction
// in flight, configurable read latency, fault classification on acceptance.
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 32,
  parameter int          READ_LAT    = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  load_ctrl,
  input  logic [1:0]  store_ctrl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [1:0]  rsp_cause
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam int          CW       = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(READ_LAT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q;
  cause_e          cause_q, cause_d;
  logic [1:0]      off_q;
  load_ctrl_e      ld_ctrl_q;

  logic            accept;
  logic [31:0]     rel_addr;
  logic            is_half, is_word, illegal, misaligned, out_of_range;
  logic [3:0]      ram_we;
  logic            ram_re;
  logic [31:0]     ram_wdata, ram_rdata;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign rel_addr  = req_addr - BASE_ADDR;

  // Fault classification of the request as presented; only used on the accept edge.
  always_comb begin
    is_half      = req_we ? (store_ctrl == ST_SH)
                          : (load_ctrl == LD_LH || load_ctrl == LD_LHU);
    is_word      = req_we ? (store_ctrl == ST_SW) : (load_ctrl == LD_LW);
    illegal      = req_we ? (store_ctrl == 2'b11) : (load_ctrl > 3'b100);
    misaligned   = (is_half && req_addr[0]) || (is_word && req_addr[1:0] != 2'b00);
    out_of_range = (rel_addr >= SPAN);
    if (illegal)           cause_d = CAUSE_ILLEGAL;
    else if (misaligned)   cause_d = CAUSE_MISALIGN;
    else if (out_of_range) cause_d = CAUSE_RANGE;
    else                   cause_d = CAUSE_NONE;
  end

  assign ram_we    = (accept && req_we && cause_d == CAUSE_NONE)
                   ? store_mask(store_ctrl_e'(store_ctrl), req_addr[1:0]) : 4'b0000;
  assign ram_re    = accept && !req_we && cause_d == CAUSE_NONE;
  assign ram_wdata = store_data(store_ctrl_e'(store_ctrl), req_wdata);

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (rel_addr[AW+1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_we || cause_d != CAUSE_NONE || READ_LAT == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = S_RESP;
      end
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      cause_q   <= CAUSE_NONE;
      off_q     <= 2'b00;
      ld_ctrl_q <= LD_LB;
    end else if (accept) begin
      we_q      <= req_we;
      cause_q   <= cause_d;
      off_q     <= req_addr[1:0];
      ld_ctrl_q <= load_ctrl_e'(load_ctrl);
    end
  end

  // Response fields are gated by RESP so reset and idle present all-zero outputs.
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_fault = rsp_valid && (cause_q != CAUSE_NONE);
  assign rsp_cause = rsp_valid ? cause_q : CAUSE_NONE;
  assign rsp_rdata = (rsp_valid && !we_q && cause_q == CAUSE_NONE)
                   ? load_extend(ld_ctrl_q, off_q, ram_rdata) : 32'h0;

endmodule

// File: tb/tb_dmem_hs.sv
// Self-checking bench for dmem_hs: directed steps followed by random traffic,
// compared against a byte-array reference model of the memory.
module tb_dmem_hs;

  localparam int          DEPTH = 32;
  localparam int          LAT   = 3;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  load_ctrl;
  logic [1:0]  store_ctrl;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_cause;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [DEPTH*4];

  dmem_hs #(
    .DEPTH_WORDS (DEPTH),
    .READ_LAT    (LAT),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .load_ctrl  (load_ctrl),
    .store_ctrl (store_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .rsp_cause  (rsp_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: access size and alignment from the control code, little-endian byte
  // array for data, sign extension by arithmetic on the assembled value.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] lc, input logic [1:0] sc,
                       output logic [31:0] e_rd, output logic [1:0] e_c, output int e_lat);
    int          size;
    bit          sgn;
    bit          ill;
    logic [31:0] off;
    off  = addr - BASE;
    sgn  = 0;
    size = 1;
    if (we) begin
      ill  = (sc == 2'd3);
      size = 1 << sc;
    end else begin
      ill = (lc > 3'd4);
      case (lc)
        3'd0:    begin size = 1; sgn = 1; end
        3'd1:    begin size = 2; sgn = 1; end
        3'd2:    size = 4;
        3'd3:    size = 1;
        3'd4:    size = 2;
        default: size = 1;
      endcase
    end
    if (ill)                             e_c = 2'd3;
    else if ((addr % size) != 0)         e_c = 2'd1;
    else if (off >= 32'(DEPTH * 4))      e_c = 2'd2;
    else                                 e_c = 2'd0;
    e_rd  = 32'h0;
    e_lat = (!we && e_c == 2'd0) ? LAT : 1;
    if (e_c == 2'd0) begin
      if (we) begin
        for (int i = 0; i < size; i++) mem_m[off + 32'(i)] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) e_rd = e_rd | (32'(mem_m[off + 32'(i)]) << (8*i));
        if (sgn && e_rd[8*size-1]) e_rd = e_rd | ~((32'd1 << (8*size)) - 32'd1);
      end
    end
  endtask

  // One complete transaction; stall holds rsp_ready low for that many cycles after rsp_valid.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] lc, input logic [1:0] sc, input int stall,
                     output logic [31:0] rd);
    logic [31:0] e_rd;
    logic [1:0]  e_c;
    int          e_lat, lat, n;
    model(we, addr, wdata, lc, sc, e_rd, e_c, e_lat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    load_ctrl  = lc;
    store_ctrl = sc;
    rsp_ready  = (stall == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    load_ctrl  = 3'($urandom_range(0, 7));
    store_ctrl = 2'($urandom_range(0, 3));
    req_we     = 1'($urandom_range(0, 1));
    lat = 1;
    while (!rsp_valid && lat < LAT + 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("latency", 32'(lat), 32'(e_lat));
    check("rsp_rdata", rsp_rdata, e_rd);
    check("rsp_fault", 32'(rsp_fault), 32'(e_c != 2'd0));
    check("rsp_cause", 32'(rsp_cause), 32'(e_c));
    rd = rsp_rdata;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_rdata", rsp_rdata, e_rd);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_handshake", 32'(req_ready), 32'd1);
    check("valid_after_handshake", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        seen_valid;
    int          o;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    load_ctrl  = '0;
    store_ctrl = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_fault", 32'(rsp_fault), 32'd0);
    check("reset_rsp_cause", 32'(rsp_cause), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Give every word a known value so later loads have defined expectations.
    for (int w = 0; w < DEPTH; w++) txn(1'b1, BASE + 32'(w * 4), $urandom, 3'd0, 3'd2 >> 0 == 3'd2 ? 2'd2 : 2'd2, 0, rd);

    txn(1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 3'd0, 2'd2, 0, rd);
    txn(1'b0, BASE + 32'h8, 32'h0, 3'd2, 2'd0, 0, rd);
    check("lw_deadbeef", rd, 32'hDEAD_BEEF);
    txn(1'b1, BASE + 32'h9, 32'h0000_00A5, 3'd0, 2'd0, 0, rd);
    txn(1'b0, BASE + 32'h9, 32'h0, 3'd0, 2'd0, 0, rd);
    check("lb_sign", rd, 32'hFFFF_FFA5);
    txn(1'b0, BASE + 32'h9, 32'h0, 3'd3, 2'd0, 0, rd);
    check("lbu_zero", rd, 32'h0000_00A5);
    txn(1'b0, BASE + 32'h8, 32'h0, 3'd2, 2'd0, 0, rd);
    check("lw_merged", rd, 32'hDEAD_A5EF);
    txn(1'b0, BASE + 32'hA, 32'h0, 3'd1, 2'd0, 0, rd);
    check("lh_upper", rd, 32'hFFFF_DEAD);

    // Fault cases, including priority between simultaneous faults.
    txn(1'b1, BASE + 32'h3, 32'h1234_5678, 3'd0, 2'd1, 0, rd);
    txn(1'b0, BASE + 32'h0, 32'h0, 3'd2, 2'd0, 0, rd);
    txn(1'b0, BASE + 32'h6, 32'h0, 3'd2, 2'd0, 0, rd);
    txn(1'b0, BASE + 32'(DEPTH * 4), 32'h0, 3'd2, 2'd0, 0, rd);
    txn(1'b0, BASE - 32'h4, 32'h0, 3'd2, 2'd0, 0, rd);
    txn(1'b0, BASE + 32'h4, 32'h0, 3'd5, 2'd0, 0, rd);
    check("illegal_rdata_zero", rd, 32'h0);
    txn(1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 3'd0, 2'd3, 0, rd);
    txn(1'b0, BASE + 32'h1, 32'h0, 3'd6, 2'd0, 0, rd);
    txn(1'b0, BASE + 32'(DEPTH * 4 + 2), 32'h0, 3'd2, 2'd0, 0, rd);
    txn(1'b1, BASE + 32'h4, 32'hCAFE_F00D, 3'd5, 2'd2, 0, rd);
    txn(1'b0, BASE + 32'h4, 32'h0, 3'd2, 2'd3, 0, rd);
    check("lw_base_plus4", rd, 32'hCAFE_F00D);

    // Consumer back-pressure for five cycles.
    txn(1'b0, BASE + 32'h8, 32'h0, 3'd2, 2'd0, 5, rd);

    // Reset during the WAIT phase of a load: the response must never appear.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = BASE + 32'h8;
    load_ctrl = 3'd2;
    rsp_ready = 1'b1;
    check("midop_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("midop_wait_valid", 32'(rsp_valid), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("midop_rst_valid", 32'(rsp_valid), 32'd0);
    check("midop_rst_ready", 32'(req_ready), 32'd1);
    check("midop_rst_rdata", rsp_rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      seen_valid = seen_valid | rsp_valid;
    end
    check("midop_no_response", 32'(seen_valid), 32'd0);
    txn(1'b0, BASE + 32'h8, 32'h0, 3'd2, 2'd0, 0, rd);
    check("ram_kept_after_reset", rd, 32'hDEAD_A5EF);

    // Random traffic around and slightly beyond the mapped window.
    for (int k = 0; k < 60; k++) begin
      o = int'($urandom_range(0, DEPTH * 4 + 15)) - 8;
      txn(1'($urandom_range(0, 1)), BASE + 32'(o), $urandom,
          3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), (k % 7 == 0) ? 2 : 0, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
